// File: rtl/systolic_array_ws_if.sv
// systolic_array_ws_if: weight-load, activation-in and result-out signals of the systolic array
interface systolic_array_ws_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 32
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  logic w_valid;
  logic w_ready;
  logic [RW-1:0] w_row;
  logic [COLS*DATA_WIDTH-1:0] w_data;
  logic in_valid;
  logic in_ready;
  logic [ROWS*DATA_WIDTH-1:0] x_i;
  logic out_valid;
  logic [COLS*ACC_WIDTH-1:0] y_o;
  logic busy;
  modport master (
    output w_valid, w_row, w_data, in_valid, x_i,
    input w_ready, in_ready, out_valid, y_o, busy
  );
  modport slave (
    input w_valid, w_row, w_data, in_valid, x_i,
    output w_ready, in_ready, out_valid, y_o, busy
  );
endinterface

// File: rtl/systolic_array_ws.sv
// systolic_array_ws: weight-stationary ROWSxCOLS systolic matrix-vector multiplier, y = x*W
module systolic_array_ws #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  systolic_array_ws_if.slave bus
);
  localparam int LAT = ROWS + COLS;
  localparam int CW = $clog2(LAT + 1);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  logic signed [DW-1:0] r_w [ROWS][COLS];
  logic signed [DW-1:0] r_a [ROWS][COLS];
  logic signed [AW-1:0] r_p [ROWS][COLS];
  logic [ROWS-1:0] r_loaded;
  logic [CW-1:0] r_inflight;
  logic [LAT-1:0] r_v;
  logic [COLS*AW-1:0] r_y;
  logic signed [DW-1:0] w_x [ROWS];
  logic signed [DW-1:0] w_a0 [ROWS];
  logic signed [DW-1:0] w_ain [ROWS][COLS];
  logic signed [AW-1:0] w_pin [ROWS][COLS];
  logic signed [2*DW-1:0] w_prod [ROWS][COLS];
  logic signed [AW-1:0] w_y [COLS];
  logic w_in_fire, w_w_fire, w_row_ok;
  assign bus.w_ready = r_inflight == '0;
  assign bus.in_ready = &r_loaded & ~bus.w_valid;
  assign bus.busy = r_inflight != '0;
  assign bus.out_valid = r_v[LAT-1];
  assign bus.y_o = r_y;
  assign w_in_fire = bus.in_valid & bus.in_ready;
  assign w_w_fire = bus.w_valid & bus.w_ready;
  assign w_row_ok = 32'(bus.w_row) < ROWS;
  always_comb
    for (int r = 0; r < ROWS; r++) w_x[r] = w_in_fire ? bus.x_i[r*DW +: DW] : '0;
  // row r enters the array r cycles late so its activation meets the partial sum from above
  for (genvar r = 0; r < ROWS; r++) begin : g_sk
    if (r == 0) begin : g_0
      assign w_a0[r] = w_x[r];
    end else begin : g_d
      logic signed [DW-1:0] r_sk [r];
      always_ff @(posedge clk)
        if (rst) r_sk <= '{default: '0};
        else begin
          r_sk[0] <= w_x[r];
          for (int i = 1; i < r; i++) r_sk[i] <= r_sk[i-1];
        end
      assign w_a0[r] = r_sk[r-1];
    end
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_r
    for (genvar c = 0; c < COLS; c++) begin : g_c
      if (c == 0) begin : g_al
        assign w_ain[r][c] = w_a0[r];
      end else begin : g_am
        assign w_ain[r][c] = r_a[r][c-1];
      end
      if (r == 0) begin : g_pt
        assign w_pin[r][c] = '0;
      end else begin : g_pm
        assign w_pin[r][c] = r_p[r-1][c];
      end
      assign w_prod[r][c] = w_ain[r][c] * r_w[r][c];
    end
  end
  // column c finishes COLS-1-c cycles early; delay it so every column lands together
  for (genvar c = 0; c < COLS; c++) begin : g_ds
    if (c == COLS - 1) begin : g_n
      assign w_y[c] = r_p[ROWS-1][c];
    end else begin : g_d
      logic signed [AW-1:0] r_d [COLS-1-c];
      always_ff @(posedge clk)
        if (rst) r_d <= '{default: '0};
        else begin
          r_d[0] <= r_p[ROWS-1][c];
          for (int i = 1; i < COLS - 1 - c; i++) r_d[i] <= r_d[i-1];
        end
      assign w_y[c] = r_d[COLS-2-c];
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_w <= '{default: '0};
      r_a <= '{default: '0};
      r_p <= '{default: '0};
      r_loaded <= '0;
      r_inflight <= '0;
      r_v <= '0;
      r_y <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          r_a[r][c] <= w_ain[r][c];
          r_p[r][c] <= w_pin[r][c] + AW'(w_prod[r][c]);
        end
      if (w_w_fire && w_row_ok) begin
        r_loaded[bus.w_row] <= 1'b1;
        for (int c = 0; c < COLS; c++) r_w[bus.w_row][c] <= bus.w_data[c*DW +: DW];
      end
      // a vector leaves the count as its result is registered, freeing weight writes that cycle
      r_inflight <= r_inflight + CW'(w_in_fire) - CW'(r_v[LAT-2]);
      r_v <= {r_v[LAT-2:0], w_in_fire};
      if (r_v[LAT-2])
        for (int c = 0; c < COLS; c++) r_y[c*AW +: AW] <= w_y[c];
    end
endmodule

// File: tb/tb_systolic_array_ws.sv
// tb_systolic_array_ws: table, directed and random checks against a matrix-vector reference model
module tb_systolic_array_ws;
  localparam int R = 4, C = 4, DW = 8, AW = 32, LAT = R + C;
  typedef struct packed { logic id; logic [7:0] wv; logic [31:0] x; logic [127:0] y; } vec_t;
  typedef struct packed { int due; logic [127:0] y; } exp_t;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0, n_chk = 0, n_fail = 0;
  int wm [R][C];
  logic [R-1:0] mask_m = '0;
  logic [127:0] y_last = '0;
  bit armed = 0;
  exp_t q[$];
  systolic_array_ws_if #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();
  systolic_array_ws #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [31:0] x4(int a, int b, int c, int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction
  function automatic logic [127:0] y4(int a, int b, int c, int d);
    return {d, c, b, a};
  endfunction
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic timeout(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(int row, logic [31:0] d);
    bit ok = 0;
    bus.w_valid = 1;
    bus.w_row = 2'(row);
    bus.w_data = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus.w_ready;
    end
    if (!ok) timeout("w_ready wait");
    step();
    bus.w_valid = 0;
  endtask
  task automatic fire(logic [31:0] x, output int k);
    bit ok = 0;
    k = 0;
    bus.in_valid = 1;
    bus.x_i = x;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      k = cyc;
    end
    if (!ok) timeout("in_ready wait");
    step();
    bus.in_valid = 0;
  endtask
  task automatic at_cycle(int t);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cyc >= t) break;
    end
    if (cyc != t) timeout("cycle wait");
  endtask
  // reference model: weight matrix, loaded mask and a queue of (due cycle, x*W) results
  always @(negedge clk) begin : sb
    bit wr_e, ov_e;
    logic [127:0] yv;
    int s;
    wr_e = 1;
    foreach (q[i]) if (q[i].due > cyc) wr_e = 0;
    ov_e = q.size() > 0 && q[0].due == cyc;
    if (ov_e) begin
      y_last = q[0].y;
      void'(q.pop_front());
    end
    if (armed) begin
      chk("out_valid", bus.out_valid, ov_e);
      chk("y_o", bus.y_o, y_last);
      chk("w_ready", bus.w_ready, wr_e);
      chk("in_ready", bus.in_ready, &mask_m & ~bus.w_valid);
      chk("busy", bus.busy, !wr_e);
    end
    if (rst) begin
      q.delete();
      mask_m = '0;
      y_last = '0;
      foreach (wm[r, c]) wm[r][c] = 0;
      armed = 1;
    end else begin
      if (bus.in_valid && &mask_m && !bus.w_valid) begin
        for (int c = 0; c < C; c++) begin
          s = 0;
          for (int r = 0; r < R; r++) s += $signed(bus.x_i[r*8 +: 8]) * wm[r][c];
          yv[c*32 +: 32] = s;
        end
        q.push_back('{cyc + LAT, yv});
      end
      if (bus.w_valid && wr_e) begin
        mask_m[bus.w_row] = 1'b1;
        for (int c = 0; c < C; c++) wm[bus.w_row][c] = $signed(bus.w_data[c*8 +: 8]);
      end
    end
  end
  initial begin
    vec_t tbl [6];
    int k, n;
    logic [7:0] got, pat;
    logic [31:0] d;
    bit ov, bz, ir;
    bus.w_valid = 0;
    bus.in_valid = 0;
    bus.w_row = 0;
    bus.w_data = 0;
    bus.x_i = 0;
    tbl[0] = '{1'b1, 8'h00, x4(1, 2, 3, 4), y4(1, 2, 3, 4)};
    tbl[1] = '{1'b0, 8'h80, x4(-128, -128, -128, -128), y4(65536, 65536, 65536, 65536)};
    tbl[2] = '{1'b0, 8'h7f, x4(-128, -128, -128, -128), y4(-65024, -65024, -65024, -65024)};
    tbl[3] = '{1'b1, 8'h00, x4(-5, 7, -128, 127), y4(-5, 7, -128, 127)};
    tbl[4] = '{1'b0, 8'hff, x4(1, 2, 3, 4), y4(-10, -10, -10, -10)};
    tbl[5] = '{1'b0, 8'h7f, x4(127, 127, 127, 127), y4(64516, 64516, 64516, 64516)};
    step();
    step();
    rst = 0;
    @(negedge clk);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset in_ready", bus.in_ready, 0);
    chk("reset w_ready", bus.w_ready, 1);
    step();
    for (int r = 0; r < 3; r++) wr(r, $urandom);
    @(negedge clk);
    chk("gate 3 rows in_ready", bus.in_ready, 0);
    step();
    wr(3, $urandom);
    @(negedge clk);
    chk("gate 4 rows in_ready", bus.in_ready, 1);
    step();
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < R; r++) begin
        d = tbl[i].id ? 32'(1) << (r * 8) : {4{tbl[i].wv}};
        wr(r, d);
      end
      fire(tbl[i].x, k);
      at_cycle(k + LAT - 1);
      chk("table early out_valid", bus.out_valid, 0);
      at_cycle(k + LAT);
      chk("table out_valid", bus.out_valid, 1);
      chk("table y", bus.y_o, tbl[i].y);
      step();
    end
    pat = 8'b11110011;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = pat[7-i];
      bus.x_i = $urandom;
      @(negedge clk);
      if (i == 0) k = cyc;
      step();
    end
    bus.in_valid = 0;
    got = '0;
    at_cycle(k + LAT);
    got = {got[6:0], bus.out_valid};
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      got = {got[6:0], bus.out_valid};
    end
    chk("stream out_valid pattern", got, pat);
    step();
    fire($urandom, k);
    bus.w_valid = 1;
    bus.w_row = 1;
    bus.w_data = $urandom;
    n = 0;
    ov = 0;
    ir = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.w_ready) begin
        ov = bus.out_valid;
        ir = bus.in_ready;
        break;
      end
      n++;
    end
    chk("lockout cycles", n, 7);
    chk("lockout write with out_valid", ov, 1);
    chk("lockout in_ready during write", ir, 0);
    step();
    bus.w_valid = 0;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.x_i = $urandom;
      bus.w_valid = $urandom_range(0, 19) == 0;
      bus.w_row = 2'($urandom_range(0, 3));
      bus.w_data = $urandom;
      step();
    end
    bus.in_valid = 0;
    bus.w_valid = 0;
    repeat (12) step();
    fire($urandom, k);
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    ov = 0;
    bz = 0;
    ir = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ov |= bus.out_valid;
      bz |= bus.busy;
      ir |= bus.in_ready;
    end
    chk("midrun reset out_valid", ov, 0);
    chk("midrun reset busy", bz, 0);
    chk("midrun reset in_ready", ir, 0);
    step();
    for (int r = 0; r < R; r++) wr(r, $urandom);
    @(negedge clk);
    chk("reload in_ready", bus.in_ready, 1);
    step();
    fire($urandom, k);
    at_cycle(k + LAT);
    chk("post-reset out_valid", bus.out_valid, 1);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
